// File: rtl/serial_word_tx.sv
// Parallel-in, serial-out word transmitter: a one-cycle word_clear strobe, then
// WIDTH data bits LSB-first with bit_valid/last_bit framing.
module serial_word_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             word_clear,
  output logic             busy
);

  // state | meaning
  // IDLE  | no word in flight, ready for a new word
  // CLEAR | one-cycle word_clear strobe ahead of bit 0
  // SHIFT | presenting data bit cnt on serial_out
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             serial_nx, bit_valid_nx, last_nx, clear_nx, busy_nx;
  logic             at_last, accept;

  assign at_last    = (cnt == CNT_LAST);
  assign load_ready = (state == IDLE) || ((state == SHIFT) && at_last);
  assign accept     = load_valid && load_ready;

  // Outputs are computed for the cycle being entered and then registered.
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    cnt_nx       = cnt;
    serial_nx    = 1'b0;
    bit_valid_nx = 1'b0;
    last_nx      = 1'b0;
    clear_nx     = 1'b0;
    busy_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = CLEAR;
          shreg_nx = load_data;
          cnt_nx   = '0;
          clear_nx = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      CLEAR: begin
        state_nx     = SHIFT;
        serial_nx    = shreg[0];
        shreg_nx     = shreg >> 1;
        cnt_nx       = '0;
        bit_valid_nx = 1'b1;
        busy_nx      = 1'b1;
      end
      SHIFT: begin
        if (at_last) begin
          cnt_nx = '0;
          if (accept) begin
            state_nx = CLEAR;
            shreg_nx = load_data;
            clear_nx = 1'b1;
            busy_nx  = 1'b1;
          end else begin
            state_nx = IDLE;
            shreg_nx = '0;
          end
        end else begin
          serial_nx    = shreg[0];
          shreg_nx     = shreg >> 1;
          cnt_nx       = cnt + CNT_W'(1);
          bit_valid_nx = 1'b1;
          busy_nx      = 1'b1;
          last_nx      = (cnt_nx == CNT_LAST);
        end
      end
      default: begin
        state_nx = IDLE;
        shreg_nx = '0;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      last_bit   <= 1'b0;
      word_clear <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      cnt        <= cnt_nx;
      serial_out <= serial_nx;
      bit_valid  <= bit_valid_nx;
      last_bit   <= last_nx;
      word_clear <= clear_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: the driver queues every accepted word; a
// monitor checks per-cycle framing against a countdown model and reassembles words.
module tb_serial_word_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         serial_out, bit_valid, last_bit, word_clear, busy;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  serial_word_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .last_bit   (last_bit),
    .word_clear (word_clear),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference timeline: 'left' counts cycles of the word in flight still to come
  // (W+1 = clear cycle, W..1 = data bits 0..W-1, 0 = idle).
  int           left = 0;
  logic [W-1:0] cur_word = '0;
  logic [W-1:0] col_word = '0;
  int           col_idx = 0;

  always begin
    logic [5:0] act, exp_v;
    logic       acc;
    @(posedge clk);
    #1;
    if (reset) begin
      left    = 0;
      col_idx = 0;
      act     = {word_clear, bit_valid, last_bit, busy, load_ready, serial_out};
      total++;
      if (act !== 6'b000010) begin
        bad++;
        $display("FAIL reset_outputs got clr/bv/last/busy/rdy/so=%b want 000010", act);
      end
    end else begin
      acc = load_valid && (left <= 1);
      if (acc) begin
        left     = W + 1;
        cur_word = load_data;
      end else if (left > 0) begin
        left--;
      end
      exp_v[5] = (left == W + 1);
      exp_v[4] = (left >= 1) && (left <= W);
      exp_v[3] = (left == 1);
      exp_v[2] = (left > 0);
      exp_v[1] = (left <= 1);
      exp_v[0] = ((left >= 1) && (left <= W)) ? cur_word[W - left] : 1'b0;
      act = {word_clear, bit_valid, last_bit, busy, load_ready, serial_out};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL cycle_outputs left=%0d got clr/bv/last/busy/rdy/so=%b want %b", left, act, exp_v);
      end
      if (bit_valid === 1'b1) begin
        if (col_idx < W) col_word[col_idx] = serial_out;
        col_idx++;
        if (last_bit === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL word_unexpected got %h want none", col_word);
          end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (col_word !== e || col_idx != W) begin
              bad++;
              $display("FAIL word_data got %h (%0d bits) want %h (%0d bits)", col_word, col_idx, e, W);
            end
          end
          col_idx = 0;
        end
      end
    end
  end

  // Present w and hold it until accepted; optionally scramble data while waiting.
  task automatic offer(input logic [W-1:0] w, input bit scramble);
    int guard;
    guard      = 0;
    load_valid = 1'b1;
    load_data  = w;
    while (!load_ready && guard < 50) begin
      @(negedge clk);
      guard++;
      if (scramble && !load_ready) load_data = W'($urandom);
    end
    if (guard >= 50) begin
      total++;
      bad++;
      $display("FAIL offer_timeout got load_ready=%b want 1 within 50 cycles", load_ready);
      load_valid = 1'b0;
    end else begin
      exp_q.push_back(load_data);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    offer(8'h05, 1'b0);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);

    offer(8'h80, 1'b0);
    offer(8'h01, 1'b0);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);

    offer(8'hAA, 1'b0);
    offer(8'h55, 1'b0);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);

    offer(8'h00, 1'b0);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Reset lands during the third data bit of 0xFF.
    offer(8'hFF, 1'b0);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    offer(8'h03, 1'b0);
    load_valid = 1'b0;
    repeat (12) @(negedge clk);

    repeat (20) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        load_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      offer(W'($urandom), 1'($urandom_range(0, 1)));
    end
    load_valid = 1'b0;
    repeat (15) @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d words pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
